inspection_sequencer: RTL and testbench
=======================================

// Module: inspection_sequencer
// PURPOSE
//  Sequences one inspection station: detects a part, polls weight, size, colour sensors in turn
//  over a req/ack handshake with timeout, then grades the part.
//  Drives the low/medium/high grade LEDs and a reject eject pulse.
//  Sits between the tt_um top pins and the sensor front-ends.
// PARAMETERS
//  TIMEOUT_CYCLES  255   max cycles a sensor req waits for ack before forced FAIL (>=1)
//  HOLD_CYCLES     1000  cycles grade outputs are held before release is allowed (>=1)
//  TMR_W           16    width of shared timeout/hold timer; must hold max(TIMEOUT,HOLD)
//  CNT_W           8     width of per-grade statistics counters
// PORTS
//  clk             in   1      system clock, rising edge
//  rst             in   1      synchronous reset, active-high
//  part_present_i  in   1      level: part in inspection position
//  sensor_req_o    out  3      one-hot request; [0] weight, [1] size, [2] colour
//  sensor_ack_i    in   1      sensor result valid this cycle (only sampled while a req is high)
//  sensor_ok_i     in   1      pass flag, qualified by sensor_ack_i
//  busy_o          out  1      high in any state except IDLE
//  grade_valid_o   out  1      grade LEDs valid (HOLD/RELEASE)
//  led_low_o       out  1      grade LOW (0 or 1 passes)
//  led_medium_o    out  1      grade MEDIUM (2 passes)
//  led_high_o      out  1      grade HIGH (3 passes)
//  eject_o         out  1      1-cycle pulse on LOW grade
//  timeout_o       out  1      sticky: >=1 sensor timed out on current part; cleared on next part start
//  stat_sel_i      in   2      STATS_EN only: 0 low, 1 medium, 2 high, 3 total
//  stat_count_o    out  CNT_W  STATS_EN only: selected counter, combinational mux
// BEHAVIOUR
//  Reset: state IDLE; every output 0; pass flags, timer, counters cleared. Reset overrides all.
//  States: IDLE -> REQ_W -> REQ_S -> REQ_C -> GRADE -> HOLD -> RELEASE -> IDLE.
//  IDLE: part_present_i=1 -> REQ_W next cycle; clear pass flags, timeout_o; timer=0.
//  REQ_x: sensor_req_o registered one-hot for x. Each cycle: ack=1 -> flag=sensor_ok_i, next REQ/GRADE,
//   timer=0; else timer++; timer==TIMEOUT_CYCLES-1 without ack -> flag=0, timeout_o=1, advance.
//   Ack and timeout in same cycle: ack wins. Ack outside REQ_x ignored.
//  Abort: part_present_i=0 in any REQ_x -> IDLE next cycle, req=0, no grade, no eject, no count.
//  GRADE (1 cycle): passes=popcount(flags); 3 HIGH, 2 MEDIUM, else LOW. Next HOLD.
//  HOLD: grade_valid_o=1, exactly one LED high; eject_o=1 on first HOLD cycle only if LOW.
//   Stays HOLD_CYCLES cycles (part removal ignored), then RELEASE.
//  RELEASE: LEDs kept; part_present_i=0 -> IDLE, LEDs and grade_valid_o drop that next cycle.
//  Latency: last ack -> grade_valid_o/eject_o high 2 cycles later.
//  Min per part: 3 (acks) + 1 GRADE + HOLD_CYCLES + 1 RELEASE cycles.
//  Reset mid-sequence: immediate return to IDLE, outputs 0; partial part discarded.
// CONFIGURATION
//  STATS_EN defined: CNT_W counters low/medium/high/total, incremented on GRADE->HOLD,
//   saturating at all-ones; cleared only by rst.
//  STATS_EN undefined: no counters; stat_count_o tied 0, stat_sel_i unused.
// STRUCTURE
//  inspection_pkg: state enum (IDLE,REQ_W,REQ_S,REQ_C,GRADE,HOLD,RELEASE), grade enum (LOW,MEDIUM,HIGH),
//   sensor index constants SNS_WEIGHT=0, SNS_SIZE=1, SNS_COLOR=2, STAT_* select codes.
//  One sub-module: inspection_stats (saturating counters + select mux), instantiated under STATS_EN.
//  FSM, shared timer, pass flags and grade decode stay in this module.
// TESTING
//  All pass: part=1, acks ok=1,1,1 -> HIGH 2 cycles after 3rd ack, eject_o=0, held HOLD_CYCLES.
//  Mixed: ok=1,0,1 -> MEDIUM; ok=0,1,0 -> LOW + one eject_o pulse on first HOLD cycle.
//  Timeout: no ack on size for TIMEOUT_CYCLES -> timeout_o=1, size=FAIL, colour req; ok=1,-,1 -> MEDIUM.
//  Abort: drop part_present_i during REQ_S -> IDLE next cycle, req=000, no LED, counters unchanged.
//  Release: part held past HOLD -> LEDs stay; drop part -> all LEDs 0 next cycle; rst mid-REQ_C -> all 0.
//  STATS_EN: 300 HIGH parts, CNT_W=8 -> high=255 saturated, total=255; STATS_EN off -> stat_count_o=0.

Source files
------------

// File: rtl/inspection_pkg.sv
// Shared types for the inspection station sequencer.
// States, grades, sensor indices, statistics select codes.
package inspection_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_W,
    REQ_S,
    REQ_C,
    GRADE,
    HOLD,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    LOW,
    MEDIUM,
    HIGH
  } grade_t;

  localparam int SNS_WEIGHT = 0;
  localparam int SNS_SIZE   = 1;
  localparam int SNS_COLOR  = 2;

  localparam logic [1:0] STAT_LOW    = 2'd0;
  localparam logic [1:0] STAT_MEDIUM = 2'd1;
  localparam logic [1:0] STAT_HIGH   = 2'd2;
  localparam logic [1:0] STAT_TOTAL  = 2'd3;

  // 3 passes HIGH, 2 MEDIUM, fewer LOW
  function automatic grade_t grade_of(
    input logic [2:0] flags
  );
    logic [1:0] n;
    n = {1'b0, flags[0]}
      + {1'b0, flags[1]}
      + {1'b0, flags[2]};
    if (n == 2'd3)
      grade_of = HIGH;
    else if (n == 2'd2)
      grade_of = MEDIUM;
    else
      grade_of = LOW;
  endfunction

endpackage

// File: rtl/inspection_stats.sv
// Per-grade saturating part counters with a select mux.
// Ports: clk, rst (sync, high), inc_i/grade_i (one graded part),
//  stat_sel_i (low/medium/high/total), stat_count_o (combinational).
module inspection_stats
  import inspection_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  grade_t           grade_i,
  input  logic [1:0]       stat_sel_i,
  output logic [CNT_W-1:0] stat_count_o
);

  logic [CNT_W-1:0] cnt_low_q;
  logic [CNT_W-1:0] cnt_med_q;
  logic [CNT_W-1:0] cnt_high_q;
  logic [CNT_W-1:0] cnt_tot_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_low_q  <= '0;
      cnt_med_q  <= '0;
      cnt_high_q <= '0;
      cnt_tot_q  <= '0;
    end else if (inc_i) begin
      cnt_tot_q <= sat_inc(cnt_tot_q);
      unique case (grade_i)
        LOW:     cnt_low_q  <= sat_inc(cnt_low_q);
        MEDIUM:  cnt_med_q  <= sat_inc(cnt_med_q);
        HIGH:    cnt_high_q <= sat_inc(cnt_high_q);
        default: ;
      endcase
    end
  end

  always_comb begin
    stat_count_o = '0;
    unique case (stat_sel_i)
      STAT_LOW:    stat_count_o = cnt_low_q;
      STAT_MEDIUM: stat_count_o = cnt_med_q;
      STAT_HIGH:   stat_count_o = cnt_high_q;
      STAT_TOTAL:  stat_count_o = cnt_tot_q;
      default:     stat_count_o = '0;
    endcase
  end

endmodule

// File: rtl/inspection_sequencer.sv
// Inspection station sequencer: polls weight/size/colour sensors, grades the part.
// Ports: clk, rst (sync, high), part_present_i, sensor_req_o[2:0], sensor_ack_i,
//  sensor_ok_i, busy_o, grade_valid_o, led_low/medium/high_o, eject_o, timeout_o,
//  stat_sel_i, stat_count_o. Define STATS_EN to build the grade counters.
module inspection_sequencer
  import inspection_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int HOLD_CYCLES    = 1000,
  parameter int TMR_W          = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             part_present_i,
  output logic [2:0]       sensor_req_o,
  input  logic             sensor_ack_i,
  input  logic             sensor_ok_i,
  output logic             busy_o,
  output logic             grade_valid_o,
  output logic             led_low_o,
  output logic             led_medium_o,
  output logic             led_high_o,
  output logic             eject_o,
  output logic             timeout_o,
  input  logic [1:0]       stat_sel_i,
  output logic [CNT_W-1:0] stat_count_o
);

  localparam logic [TMR_W-1:0] TO_LAST =
    TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST =
    TMR_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  state_t           req_next;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       req_q, req_d;
  logic             to_q, to_d;
  logic             eject_q, eject_d;
  grade_t           grade_q, grade_d;
  logic             stat_inc;

  assign req_next =
    (state_q == REQ_W) ? REQ_S :
    (state_q == REQ_S) ? REQ_C : GRADE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      flags_q <= '0;
      req_q   <= '0;
      to_q    <= 1'b0;
      eject_q <= 1'b0;
      grade_q <= LOW;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      flags_q <= flags_d;
      req_q   <= req_d;
      to_q    <= to_d;
      eject_q <= eject_d;
      grade_q <= grade_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    flags_d  = flags_q;
    to_d     = to_q;
    grade_d  = grade_q;
    eject_d  = 1'b0;
    stat_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (part_present_i) begin
          state_d = REQ_W;
          flags_d = '0;
          to_d    = 1'b0;
          tmr_d   = '0;
        end
      end
      // req_q is one-hot for the sensor being polled,
      // so it doubles as the flag write mask
      REQ_W, REQ_S, REQ_C: begin
        if (!part_present_i) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (sensor_ack_i) begin
          flags_d = (flags_q & ~req_q)
                  | (req_q & {3{sensor_ok_i}});
          state_d = req_next;
          tmr_d   = '0;
        end else if (tmr_q == TO_LAST) begin
          flags_d = flags_q & ~req_q;
          to_d    = 1'b1;
          state_d = req_next;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GRADE: begin
        grade_d  = grade_of(flags_q);
        eject_d  = (grade_d == LOW);
        stat_inc = 1'b1;
        state_d  = HOLD;
        tmr_d    = '0;
      end
      HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = RELEASE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!part_present_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d             = '0;
    req_d[SNS_WEIGHT] = (state_d == REQ_W);
    req_d[SNS_SIZE]   = (state_d == REQ_S);
    req_d[SNS_COLOR]  = (state_d == REQ_C);
  end

  assign sensor_req_o  = req_q;
  assign busy_o        = (state_q != IDLE);
  assign grade_valid_o = (state_q == HOLD)
                      || (state_q == RELEASE);
  assign led_low_o     = grade_valid_o && (grade_q == LOW);
  assign led_medium_o  = grade_valid_o && (grade_q == MEDIUM);
  assign led_high_o    = grade_valid_o && (grade_q == HIGH);
  assign eject_o       = eject_q;
  assign timeout_o     = to_q;

`ifdef STATS_EN
  inspection_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk          (clk),
    .rst          (rst),
    .inc_i        (stat_inc),
    .grade_i      (grade_d),
    .stat_sel_i   (stat_sel_i),
    .stat_count_o (stat_count_o)
  );
`else
  logic unused_stats;
  assign unused_stats = ^{stat_sel_i, stat_inc};
  assign stat_count_o = '0;
`endif

endmodule

// File: tb/tb_inspection_sequencer.sv
// Scoreboard bench for inspection_sequencer.
// Stimulus pushes expected grades; a negedge monitor pops and compares.
module tb_inspection_sequencer;

  localparam int TO   = 10;
  localparam int HOLD = 8;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          part;
  logic          ack;
  logic          ok;
  logic [1:0]    sel;
  logic [2:0]    req;
  logic          busy;
  logic          gvalid;
  logic          led_l;
  logic          led_m;
  logic          led_h;
  logic          eject;
  logic          tout;
  logic [CW-1:0] scount;

  int n_checks = 0;
  int n_fail   = 0;
  int ejects     = 0;
  int exp_ejects = 0;
  int exp_cnt[4] = '{0, 0, 0, 0};
  logic [3:0] exp_q[$];
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  inspection_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .HOLD_CYCLES    (HOLD),
    .TMR_W          (16),
    .CNT_W          (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .part_present_i (part),
    .sensor_req_o   (req),
    .sensor_ack_i   (ack),
    .sensor_ok_i    (ok),
    .busy_o         (busy),
    .grade_valid_o  (gvalid),
    .led_low_o      (led_l),
    .led_medium_o   (led_m),
    .led_high_o     (led_h),
    .eject_o        (eject),
    .timeout_o      (tout),
    .stat_sel_i     (sel),
    .stat_count_o   (scount)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: compare on the first HOLD cycle
  always @(negedge clk) begin
    logic [3:0] e;
    if (eject) ejects++;
    if (gvalid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_grade: leds %b none expected",
                 {led_h, led_m, led_l});
      end else begin
        e = exp_q.pop_front();
        check("grade_leds", {29'd0, led_h, led_m, led_l},
              {29'd0, e[2:0]});
        check("eject_first_hold", {31'd0, eject},
              {31'd0, e[3]});
      end
    end
    prev_valid = gvalid;
  end

  function automatic void model_count(input logic [2:0] leds);
    int i;
    i = leds[2] ? 2 : leds[1] ? 1 : 0;
    if (exp_cnt[i] < 255) exp_cnt[i]++;
    if (exp_cnt[3] < 255) exp_cnt[3]++;
  endfunction

  // leds given as {high, medium, low}
  task automatic do_part(
    input logic [2:0] ok_v,
    input logic [2:0] noack,
    input logic [2:0] exp_leds,
    input logic       exp_to,
    input bit         early_drop,
    input bit         quick
  );
    int n;
    exp_q.push_back({exp_leds == 3'b001, exp_leds});
    if (exp_leds == 3'b001) exp_ejects++;
    model_count(exp_leds);
    part = 1'b1;
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (!req[s] && n < 20) begin
        step(1);
        n++;
      end
      check($sformatf("req_onehot_%0d", s),
            {29'd0, req}, 32'd1 << s);
      if (s == 0 && !quick)
        check("timeout_cleared", {31'd0, tout}, 0);
      if (noack[s]) begin
        n = 0;
        while (req[s] && n < TO + 5) begin
          step(1);
          n++;
        end
        check("timeout_len", n, TO);
      end else begin
        ack = 1'b1;
        ok  = ok_v[s];
        step(1);
        ack = 1'b0;
        ok  = 1'b0;
      end
    end
    if (!noack[2]) begin
      if (!quick)
        check("grade_latency_1", {31'd0, gvalid}, 0);
      step(1);
      check("grade_latency_2", {31'd0, gvalid}, 1);
    end else begin
      n = 0;
      while (!gvalid && n < 10) begin
        step(1);
        n++;
      end
      check("grade_after_to", {31'd0, gvalid}, 1);
    end
    if (!quick) begin
      check("timeout_flag", {31'd0, tout}, {31'd0, exp_to});
      check("busy_hold", {31'd0, busy}, 1);
    end
    if (early_drop) begin
      part = 1'b0;
      n = 0;
      while (gvalid && n < HOLD + 10) begin
        step(1);
        n++;
      end
      check("hold_len", n, HOLD + 1);
    end else if (!quick) begin
      step(HOLD + 4);
      check("release_kept", {29'd0, led_h, led_m, led_l},
            {29'd0, exp_leds});
      part = 1'b0;
      step(1);
      check("release_drop",
            {28'd0, gvalid, led_h, led_m, led_l}, 0);
      check("idle_busy", {31'd0, busy}, 0);
    end else begin
      step(HOLD);
      part = 1'b0;
      step(2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timed out at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst  = 1'b1;
    part = 1'b0;
    ack  = 1'b0;
    ok   = 1'b0;
    sel  = 2'd0;
    step(3);
    check("rst_req", {29'd0, req}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_leds",
          {28'd0, gvalid, led_h, led_m, led_l}, 0);
    check("rst_eject_to", {30'd0, eject, tout}, 0);
    check("rst_stat", {24'd0, scount}, 0);
    rst = 1'b0;
    step(2);

    do_part(3'b111, 3'b000, 3'b100, 1'b0, 0, 0);
    do_part(3'b101, 3'b000, 3'b010, 1'b0, 0, 0);
    do_part(3'b010, 3'b000, 3'b001, 1'b0, 1, 0);
    do_part(3'b101, 3'b010, 3'b010, 1'b1, 0, 0);
    do_part(3'b111, 3'b000, 3'b100, 1'b0, 1, 0);

    // abort during the size request
    part = 1'b1;
    n = 0;
    while (!req[0] && n < 20) begin
      step(1);
      n++;
    end
    ack = 1'b1;
    ok  = 1'b1;
    step(1);
    ack = 1'b0;
    check("abort_in_size", {29'd0, req}, 3'b010);
    part = 1'b0;
    step(1);
    check("abort_req", {29'd0, req}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    step(5);
    check("abort_no_grade", {31'd0, gvalid}, 0);

    // reset while waiting on colour
    part = 1'b1;
    n = 0;
    while (!req[0] && n < 20) begin
      step(1);
      n++;
    end
    ack = 1'b1;
    ok  = 1'b1;
    step(2);
    ack = 1'b0;
    check("rst_mid_in_colour", {29'd0, req}, 3'b100);
    rst = 1'b1;
    step(1);
    check("rst_mid_req", {29'd0, req}, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_outs",
          {26'd0, gvalid, led_h, led_m, led_l, eject, tout}, 0);
    rst  = 1'b0;
    part = 1'b0;
    step(3);
    check("rst_mid_no_grade", {31'd0, gvalid}, 0);

    do_part(3'b011, 3'b000, 3'b010, 1'b0, 0, 0);

`ifdef STATS_EN
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("stat_%0d", i), {24'd0, scount}, exp_cnt[i]);
    end
    for (int p = 0; p < 300; p++)
      do_part(3'b111, 3'b000, 3'b100, 1'b0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("stat_sat_%0d", i), {24'd0, scount},
            exp_cnt[i]);
    end
`else
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      check($sformatf("stat_off_%0d", i), {24'd0, scount}, 0);
    end
`endif

    step(5);
    check("scoreboard_empty", exp_q.size(), 0);
    check("eject_count", ejects, exp_ejects);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
